data_mem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory interface (MemRead/MemWrite/MemAddr/MemWriteData).

---
 rtl/dm_pkg.sv | 15 +
 rtl/dm_storage.sv | 29 ++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, latency
// bounds and the latency counter width.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/dm_storage.sv
// Word array for the data-memory responder: one synchronous write port and
// one combinational read port, zero-initialised at time 0 and never reset.
module dm_storage #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    // Rounded up to a power of two so every index is in bounds; the responder
    // never issues an access at or above DEPTH_WORDS.
    localparam int SLOTS = 1 << AW;

    logic [31:0] mem_q [SLOTS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data interface: one word access at a
// time with fixed LATENCY, ready/valid handshake and request error flagging.
//
//  state | meaning
//  IDLE  | ReqReady=1, waiting for MemRead/MemWrite
//  WAIT  | request latched, counting down remaining latency
//  RESP  | one-cycle RespValid; write commits at the edge ending this state
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemAddr,
    input  logic [31:0] MemWriteData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] MemReadData,
    output logic        AddrError
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must lie within 1..15");
    end

    dm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d, wr_q, wr_d;
    logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic             accept, req_err, mem_we;
    logic [31:0]      mem_rdata;

    assign accept = ReqReady & (MemRead | MemWrite);

    // Full 30-bit word index is compared so out-of-range addresses never alias.
    assign req_err = (addr_q[1:0] != 2'b00)
                  || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS))
                  || (rd_q && wr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    addr_d  = MemAddr;
                    wdata_d = MemWriteData;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates RESP so a dropped request neither responds nor commits.
    always_comb begin
        ReqReady    = 1'b0;
        RespValid   = 1'b0;
        AddrError   = 1'b0;
        MemReadData = '0;
        mem_we      = 1'b0;
        unique case (state_q)
            IDLE: ReqReady = !rst;
            RESP: begin
                if (!rst) begin
                    RespValid = 1'b1;
                    AddrError = req_err;
                    mem_we    = wr_q && !req_err;
                    if (rd_q && !req_err) begin
                        MemReadData = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    dm_storage #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_storage (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .raddr_i (addr_q[AW+1:2]),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=2 and one
// at LATENCY=3, both with 256 words, checked against a bench-side memory model.
module tb_data_mem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        resp  [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [2][256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_lat2 (
        .clk(clk), .rst(rst[0]), .MemRead(rd[0]), .MemWrite(wr[0]),
        .MemAddr(addr[0]), .MemWriteData(wdata[0]), .ReqReady(ready[0]),
        .RespValid(resp[0]), .MemReadData(rdata[0]), .AddrError(err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut_lat3 (
        .clk(clk), .rst(rst[1]), .MemRead(rd[1]), .MemWrite(wr[1]),
        .MemAddr(addr[1]), .MemWriteData(wdata[1]), .ReqReady(ready[1]),
        .RespValid(resp[1]), .MemReadData(rdata[1]), .AddrError(err[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every RespValid pulse.
    always @(negedge clk) begin
        exp_t e;
        int   qs;
        for (int u = 0; u < 2; u++) begin
            qs = (u == 0) ? q0.size() : q1.size();
            if (resp[u] === 1'b1) begin
                if (qs == 0) begin
                    chk("spurious_resp", 64'(resp[u]), 64'd0);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    chk("rdata", 64'(rdata[u]), 64'(e.data));
                    chk("addr_err", 64'(err[u]), 64'(e.err));
                end
            end else begin
                chk("idle_outputs", 64'({err[u], rdata[u]}), 64'd0);
            end
        end
    end

    task automatic do_req(input int u, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   k;
        int   lat;
        lat = (u == 0) ? 2 : 3;
        k = 0;
        while (ready[u] !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 64'(ready[u]), 64'd1);
        e.err  = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256) || (r && w);
        e.data = (r && !e.err) ? model[u][a[9:2]] : 32'h0;
        if (w && !e.err) model[u][a[9:2]] = d;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
        @(posedge clk);
        #1;
        // Scramble the bus after acceptance: the latched request must win.
        rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = $urandom; wdata[u] = $urandom;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (resp[u] !== 1'b1) chk("busy_not_ready", 64'(ready[u]), 64'd0);
        end while (resp[u] !== 1'b1 && k < 20);
        chk("latency", 64'(k), 64'(lat));
        chk("ready_in_resp", 64'(ready[u]), 64'd0);
        @(negedge clk);
        chk("ready_after_resp", 64'(ready[u]), 64'd1);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
            for (int i = 0; i < 256; i++) model[u][i] = 32'h0;
        end

        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready0", 64'(ready[0]), 64'd0);
            chk("rst_ready1", 64'(ready[1]), 64'd0);
            chk("rst_resp0", 64'(resp[0]), 64'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        do_req(0, 1, 0, 32'h0, 32'h0);
        do_req(0, 0, 1, 32'h10, 32'hDEADBEEF);
        do_req(0, 1, 0, 32'h10, 32'h0);
        do_req(0, 1, 0, 32'h13, 32'h0);
        do_req(0, 1, 0, 32'h10, 32'h0);
        do_req(0, 0, 1, 32'h400, 32'h12345678);
        do_req(0, 1, 0, 32'h0, 32'h0);
        do_req(0, 0, 1, 32'hFFFF_FFFC, 32'hCAFEF00D);
        do_req(0, 1, 0, 32'h0, 32'h0);
        do_req(0, 0, 1, 32'h3FC, 32'h600DCAFE);
        do_req(0, 1, 0, 32'h3FC, 32'h0);
        do_req(0, 0, 1, 32'h20, 32'h0BADF00D);
        do_req(0, 1, 1, 32'h20, 32'hA5A5A5A5);
        do_req(0, 1, 0, 32'h20, 32'h0);

        repeat (24) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            op = $urandom_range(0, 4);
            do_req(0, op != 1 && op != 2, op == 1 || op == 2 || op == 4, a, $urandom);
        end

        // LATENCY=3: reset during WAIT drops the write
        do_req(1, 0, 1, 32'h30, 32'h11111111);
        rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'h22222222;
        @(posedge clk);
        #1;
        wr[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait_resp", 64'(resp[1]), 64'd0);
            chk("rst_wait_ready", 64'(ready[1]), 64'd0);
        end
        rst[1] = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(ready[1]), 64'd1);
        do_req(1, 1, 0, 32'h30, 32'h0);

        // LATENCY=3: reset arriving in RESP suppresses response and commit
        wr[1] = 1'b1; addr[1] = 32'h34; wdata[1] = 32'h33333333;
        @(posedge clk);
        #1;
        wr[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("rst_resp_resp", 64'(resp[1]), 64'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        do_req(1, 1, 0, 32'h34, 32'h0);
        do_req(1, 0, 1, 32'h3FC, 32'h7E57DA7A);
        do_req(1, 1, 0, 32'h3FC, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
